// File: rtl/ladybird_config_pkg.sv
// Shared configuration for the ladybird core: datapath width, instruction
// size and the entry type carried by the fetch queue.
package ladybird_config;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/ladybird_fetch_queue.sv
// Small synchronous FIFO of fetch entries between the IFU and decode.
// Push and pop may happen together at any occupancy (including full); flush
// empties the queue and overrides a same-cycle push or pop. The head is read
// straight from storage, so a pushed entry is visible one cycle later.
module ladybird_fetch_queue
   import ladybird_config::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  fetch_entry_t  i_wdata,
   output fetch_entry_t  o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = i_push & ~i_flush;
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; flush restarts both pointers at 0.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // Entry storage; contents only matter where count says they are live.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/ladybird_fetch_ctrl.sv
// Fetch control: issues sequential PCs to the IFU and queues its responses
// for decode.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both high. Once o_ifu_pc_valid is raised, o_ifu_pc_valid and o_ifu_pc stay
// unchanged until the transfer (never withdrawn, not even by a redirect).
// The IFU answers with i_ifu_inst_valid for one cycle and cannot be stalled,
// so every request is issued only when a queue slot is reserved for it:
// inflight + pending request + queued - popping must stay below QUEUE_DEPTH.
// Decode consumes the head on o_dec_valid & i_dec_ready.
// A redirect flushes the queue and arms drop_cnt so that every response
// belonging to the old path (including a request still waiting to issue) is
// discarded on arrival.
module ladybird_fetch_ctrl
   import ladybird_config::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              QUEUE_DEPTH  = 4
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] o_ifu_pc,
   output logic            o_ifu_pc_valid,
   input  logic            i_ifu_pc_ready,
   input  logic [XLEN-1:0] i_ifu_inst,
   input  logic            i_ifu_inst_valid,
   input  logic [XLEN-1:0] i_ifu_inst_pc,
   output logic [XLEN-1:0] o_dec_inst,
   output logic [XLEN-1:0] o_dec_pc,
   output logic            o_dec_valid,
   input  logic            i_dec_ready
);

   localparam int CW  = $clog2(QUEUE_DEPTH) + 1;
   localparam int CSW = CW + 1;

   logic [XLEN-1:0] r_next_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_req_valid;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_drop_cnt;

   logic            w_accept;
   logic            w_pop;
   logic            w_push;
   logic            w_load;
   logic            w_credit_ok;
   logic [CSW-1:0]  w_committed;
   logic [CW-1:0]   w_q_count;
   logic            w_q_full;
   logic            w_q_empty;
   fetch_entry_t    w_q_head;
   fetch_entry_t    w_push_entry;
   logic            w_unused_pc_lsb;

   // Fetch is word aligned; the low redirect bits carry no information.
   assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

   assign w_accept = r_req_valid & i_ifu_pc_ready;
   // A redirect flushes the queue, so a pop in that cycle does not count.
   assign w_pop    = i_dec_ready & ~w_q_empty & ~i_redirect_valid;
   // Responses are dropped while old-path responses are still owed, and in
   // the redirect cycle itself.
   assign w_push   = i_ifu_inst_valid & ~i_redirect_valid & (r_drop_cnt == '0);

   assign w_committed = CSW'(r_inflight) + CSW'(r_req_valid)
                      + CSW'(w_q_count) - CSW'(w_pop);
   assign w_credit_ok = (w_committed < CSW'(QUEUE_DEPTH));
   assign w_load      = ~i_redirect_valid & (~r_req_valid | w_accept) & w_credit_ok;

   assign w_push_entry.inst = i_ifu_inst;
   assign w_push_entry.pc   = i_ifu_inst_pc;

   ladybird_fetch_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk     (clk),
      .nrst    (nrst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .i_wdata (w_push_entry),
      .o_head  (w_q_head),
      .o_count (w_q_count),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

   // PC generation and the request register feeding the IFU.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_next_pc   <= RESET_VECTOR;
         r_req_pc    <= RESET_VECTOR;
         r_req_valid <= 1'b0;
      end else begin
         if (i_redirect_valid) begin
            r_next_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
         end else if (w_load) begin
            r_next_pc <= r_next_pc + XLEN'(INST_BYTES);
         end
         if (w_load) begin
            r_req_valid <= 1'b1;
            r_req_pc    <= r_next_pc;
         end else if (w_accept) begin
            r_req_valid <= 1'b0;
         end
      end
   end

   // Outstanding-request and stale-response counters.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_inflight <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_accept) - CW'(i_ifu_inst_valid);
         if (i_redirect_valid) begin
            r_drop_cnt <= r_inflight + CW'(r_req_valid) - CW'(i_ifu_inst_valid);
         end else if (i_ifu_inst_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
         end
      end
   end

   assign o_ifu_pc_valid = r_req_valid;
   assign o_ifu_pc       = r_req_pc;
   assign o_dec_valid    = ~w_q_empty;
   assign o_dec_inst     = w_q_empty ? '0 : w_q_head.inst;
   assign o_dec_pc       = w_q_empty ? '0 : w_q_head.pc;

   // A kept response must always find a free slot.
   assert property (@(posedge clk) disable iff (!nrst)
                    !(w_push && w_q_full && !w_pop));

endmodule

// File: tb/tb_ladybird_fetch_ctrl.sv
// Bench for ladybird_fetch_ctrl: an IFU model with fixed latency, a decode
// sink, and a scoreboard holding the PCs decode must see in order.
module tb_ladybird_fetch_ctrl;

   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam int          DEPTH = 4;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic [31:0] o_ifu_pc;
   logic        o_ifu_pc_valid;
   logic        i_ifu_pc_ready = 1'b0;
   logic [31:0] i_ifu_inst = '0;
   logic        i_ifu_inst_valid = 1'b0;
   logic [31:0] i_ifu_inst_pc = '0;
   logic [31:0] o_dec_inst;
   logic [31:0] o_dec_pc;
   logic        o_dec_valid;
   logic        i_dec_ready = 1'b0;

   ladybird_fetch_ctrl #(
      .RESET_VECTOR (RV),
      .QUEUE_DEPTH  (DEPTH)
   ) dut (
      .clk              (clk),
      .nrst             (nrst),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_ifu_pc         (o_ifu_pc),
      .o_ifu_pc_valid   (o_ifu_pc_valid),
      .i_ifu_pc_ready   (i_ifu_pc_ready),
      .i_ifu_inst       (i_ifu_inst),
      .i_ifu_inst_valid (i_ifu_inst_valid),
      .i_ifu_inst_pc    (i_ifu_inst_pc),
      .o_dec_inst       (o_dec_inst),
      .o_dec_pc         (o_dec_pc),
      .o_dec_valid      (o_dec_valid),
      .i_dec_ready      (i_dec_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   // ---------------- model state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int lat      = 2;
   int ready_mode = 0;  // 0: always ready, 1: random, other: left to the test
   int dec_mode   = 0;  // same encoding for decode ready
   int n_acc = 0;
   int n_pop = 0;
   int n_resp = 0;

   logic [31:0] rq_pc[$];    // IFU: accepted addresses awaiting response
   int          rq_due[$];   // IFU: cycle at which each response is returned
   logic [31:0] exp_q[$];    // scoreboard: PCs decode must receive, in order
   logic [31:0] pop_log[$];  // PCs actually consumed by decode
   logic [31:0] req_exp = RV;
   logic [31:0] stale_pc = '0;
   logic [31:0] hold_pc = '0;
   logic        stale_valid = 1'b0;
   logic        hold_pending = 1'b0;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic tick();
      logic        acc;
      logic        pop;
      logic [31:0] exp_pc;
      if (ready_mode == 0)      i_ifu_pc_ready = 1'b1;
      else if (ready_mode == 1) i_ifu_pc_ready = 1'($urandom_range(0, 1));
      if (dec_mode == 0)        i_dec_ready = 1'b1;
      else if (dec_mode == 1)   i_dec_ready = 1'($urandom_range(0, 1));
      if (rq_pc.size() > 0 && rq_due[0] <= cyc) begin
         i_ifu_inst_valid = 1'b1;
         i_ifu_inst_pc    = rq_pc[0];
         i_ifu_inst       = inst_of(rq_pc[0]);
         void'(rq_pc.pop_front());
         void'(rq_due.pop_front());
         n_resp++;
      end else begin
         i_ifu_inst_valid = 1'b0;
         i_ifu_inst       = $urandom;
         i_ifu_inst_pc    = $urandom;
      end

      if (hold_pending) begin
         n_checks++;
         if (o_ifu_pc_valid !== 1'b1 || o_ifu_pc !== hold_pc)
            $display("FAIL req_hold: valid=%b pc=%h, required valid=1 pc=%h",
                     o_ifu_pc_valid, o_ifu_pc, hold_pc);
         else n_pass++;
      end

      acc = o_ifu_pc_valid & i_ifu_pc_ready;
      pop = o_dec_valid & i_dec_ready & ~i_redirect_valid;

      if (pop) begin
         n_pop++;
         pop_log.push_back(o_dec_pc);
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL dec_unexpected: pc=%h consumed, required no entry", o_dec_pc);
         end else begin
            exp_pc = exp_q.pop_front();
            if (o_dec_pc !== exp_pc || o_dec_inst !== inst_of(exp_pc))
               $display("FAIL dec_entry: pc=%h inst=%h, required pc=%h inst=%h",
                        o_dec_pc, o_dec_inst, exp_pc, inst_of(exp_pc));
            else n_pass++;
         end
      end

      if (acc) begin
         n_acc++;
         rq_pc.push_back(o_ifu_pc);
         rq_due.push_back(cyc + lat);
         if (stale_valid && o_ifu_pc === stale_pc) begin
            stale_valid = 1'b0;
         end else begin
            n_checks++;
            if (o_ifu_pc !== req_exp)
               $display("FAIL req_pc: pc=%h, required %h", o_ifu_pc, req_exp);
            else n_pass++;
            exp_q.push_back(req_exp);
            req_exp = req_exp + 32'd4;
         end
      end

      if (i_redirect_valid) begin
         exp_q.delete();
         req_exp     = {i_redirect_pc[31:2], 2'b00};
         stale_valid = o_ifu_pc_valid & ~acc;
         stale_pc    = o_ifu_pc;
      end

      hold_pending = o_ifu_pc_valid & ~i_ifu_pc_ready;
      hold_pc      = o_ifu_pc;

      @(posedge clk);
      #1;
      cyc++;
      i_redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      nrst             = 1'b0;
      i_redirect_valid = 1'b0;
      i_ifu_inst_valid = 1'b0;
      i_ifu_pc_ready   = 1'b0;
      i_dec_ready      = 1'b0;
      rq_pc.delete();
      rq_due.delete();
      exp_q.delete();
      pop_log.delete();
      repeat (3) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      nrst         = 1'b1;
      req_exp      = RV;
      stale_valid  = 1'b0;
      hold_pending = 1'b0;
      n_acc        = 0;
      n_pop        = 0;
      n_resp       = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      nrst = 1'b0;
      i_ifu_pc_ready = 1'b1;
      i_dec_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (o_ifu_pc_valid !== 1'b0) $display("FAIL rst_pc_valid: %b, required 0", o_ifu_pc_valid);
      else n_pass++;
      n_checks++;
      if (o_ifu_pc !== RV) $display("FAIL rst_pc: %h, required %h", o_ifu_pc, RV);
      else n_pass++;
      n_checks++;
      if (o_dec_valid !== 1'b0) $display("FAIL rst_dec_valid: %b, required 0", o_dec_valid);
      else n_pass++;
      n_checks++;
      if (o_dec_inst !== 32'h0 || o_dec_pc !== 32'h0)
         $display("FAIL rst_dec_data: inst=%h pc=%h, required 0/0", o_dec_inst, o_dec_pc);
      else n_pass++;
      do_reset();
      ready_mode = 2;
      i_ifu_pc_ready = 1'b0;
      dec_mode = 0;
      tick();
      n_checks++;
      if (o_ifu_pc_valid !== 1'b1 || o_ifu_pc !== RV)
         $display("FAIL first_req: valid=%b pc=%h, required 1/%h", o_ifu_pc_valid, o_ifu_pc, RV);
      else n_pass++;
   endtask

   task automatic test_stream();
      int gaps;
      do_reset();
      lat = 2; ready_mode = 0; dec_mode = 0;
      for (int i = 0; i < 200 && n_pop < 40; i++) tick();
      n_checks++;
      if (n_pop < 40) $display("FAIL stream_progress: %0d pops, required 40", n_pop);
      else n_pass++;
      gaps = 0;
      for (int i = 0; i < 30; i++) begin
         if (!o_dec_valid) gaps++;
         tick();
      end
      n_checks++;
      if (gaps != 0) $display("FAIL stream_gaps: %0d empty cycles, required 0", gaps);
      else n_pass++;
      n_checks++;
      if (pop_log.size() < 6) $display("FAIL stream_log: %0d entries, required >= 6", pop_log.size());
      else if (pop_log[5] !== 32'h14) $display("FAIL stream_pc5: %h, required 00000014", pop_log[5]);
      else n_pass++;
   endtask

   task automatic test_dec_stall();
      do_reset();
      lat = 2; ready_mode = 0; dec_mode = 3;
      i_dec_ready = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (n_acc != DEPTH) $display("FAIL stall_accepts: %0d, required %0d", n_acc, DEPTH);
      else n_pass++;
      n_checks++;
      if (o_ifu_pc_valid !== 1'b0 || o_dec_valid !== 1'b1)
         $display("FAIL stall_state: pc_valid=%b dec_valid=%b, required 0/1", o_ifu_pc_valid, o_dec_valid);
      else n_pass++;
      i_dec_ready = 1'b1;
      tick();
      i_dec_ready = 1'b0;
      repeat (12) tick();
      n_checks++;
      if (n_acc != DEPTH + 1 || n_pop != 1)
         $display("FAIL stall_release: accepts=%0d pops=%0d, required %0d/1", n_acc, n_pop, DEPTH + 1);
      else n_pass++;
      n_checks++;
      if (o_ifu_pc_valid !== 1'b0) $display("FAIL stall_refill: pc_valid=%b, required 0", o_ifu_pc_valid);
      else n_pass++;
   endtask

   task automatic test_ifu_stall();
      do_reset();
      lat = 2; ready_mode = 3; dec_mode = 0;
      i_ifu_pc_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (o_ifu_pc_valid !== 1'b1 || o_ifu_pc !== RV)
            $display("FAIL ifu_stall_%0d: valid=%b pc=%h, required 1/%h", i, o_ifu_pc_valid, o_ifu_pc, RV);
         else n_pass++;
         tick();
      end
      ready_mode = 0;
      for (int i = 0; i < 50 && n_pop < 4; i++) tick();
      n_checks++;
      if (n_pop < 4) $display("FAIL ifu_stall_resume: %0d pops, required 4", n_pop);
      else n_pass++;
   endtask

   task automatic test_redirect();
      int  base;
      bit  seen;
      do_reset();
      lat = 4; ready_mode = 3; dec_mode = 0;
      i_ifu_pc_ready = 1'b0;
      tick();
      i_ifu_pc_ready = 1'b1;
      tick();
      tick();
      i_ifu_pc_ready = 1'b0;
      n_checks++;
      if (o_ifu_pc_valid !== 1'b1 || o_ifu_pc !== 32'h8)
         $display("FAIL redir_pending: valid=%b pc=%h, required 1/00000008", o_ifu_pc_valid, o_ifu_pc);
      else n_pass++;
      i_redirect_valid = 1'b1;
      i_redirect_pc = 32'h100;
      tick();
      base = n_resp;
      n_checks++;
      if (o_dec_valid !== 1'b0) $display("FAIL redir_flush: dec_valid=%b, required 0", o_dec_valid);
      else n_pass++;
      ready_mode = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (o_dec_valid) seen = 1'b1;
         else tick();
      end
      n_checks++;
      if (!seen || (n_resp - base) != 4 || o_dec_pc !== 32'h100)
         $display("FAIL redir_resume: seen=%b responses=%0d pc=%h, required 1/4/00000100",
                  seen, n_resp - base, o_dec_pc);
      else n_pass++;
      tick();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_dec_valid) seen = 1'b1;
         else tick();
      end
      n_checks++;
      if (!seen || o_dec_pc !== 32'h104)
         $display("FAIL redir_second: seen=%b pc=%h, required 1/00000104", seen, o_dec_pc);
      else n_pass++;
   endtask

   task automatic test_redirect_collision();
      bit found;
      bit seen;
      do_reset();
      lat = 2; ready_mode = 0; dec_mode = 0;
      for (int i = 0; i < 100 && n_pop < 6; i++) tick();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (o_dec_valid && rq_pc.size() > 0 && rq_due[0] <= cyc) found = 1'b1;
         else tick();
      end
      n_checks++;
      if (!found) $display("FAIL collision_setup: found=%b, required 1", found);
      else n_pass++;
      i_redirect_valid = 1'b1;
      i_redirect_pc = 32'h203;
      tick();
      n_checks++;
      if (o_dec_valid !== 1'b0 || o_ifu_pc_valid !== 1'b0)
         $display("FAIL collision_flush: dec_valid=%b pc_valid=%b, required 0/0", o_dec_valid, o_ifu_pc_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (o_ifu_pc_valid !== 1'b1 || o_ifu_pc !== 32'h200)
         $display("FAIL collision_target: valid=%b pc=%h, required 1/00000200", o_ifu_pc_valid, o_ifu_pc);
      else n_pass++;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (o_dec_valid) seen = 1'b1;
         else tick();
      end
      n_checks++;
      if (!seen || o_dec_pc !== 32'h200)
         $display("FAIL collision_dec: seen=%b pc=%h, required 1/00000200", seen, o_dec_pc);
      else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      lat = 2; ready_mode = 0; dec_mode = 0;
      repeat (6) tick();
      i_redirect_valid = 1'b1;
      i_redirect_pc = 32'hFFFF_FFF8;
      tick();
      pop_log.delete();
      for (int i = 0; i < 40 && pop_log.size() < 4; i++) tick();
      n_checks++;
      if (pop_log.size() < 4)
         $display("FAIL wrap_progress: %0d pops, required 4", pop_log.size());
      else if (pop_log[1] !== 32'hFFFF_FFFC || pop_log[2] !== 32'h0 || pop_log[3] !== 32'h4)
         $display("FAIL wrap_seq: %h %h %h, required fffffffc 00000000 00000004",
                  pop_log[1], pop_log[2], pop_log[3]);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      lat = 2; ready_mode = 0; dec_mode = 0;
      repeat (10) tick();
      nrst = 1'b0;
      i_ifu_inst_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      n_checks++;
      if (o_ifu_pc_valid !== 1'b0 || o_ifu_pc !== RV || o_dec_valid !== 1'b0)
         $display("FAIL midrst_outputs: pc_valid=%b pc=%h dec_valid=%b, required 0/%h/0",
                  o_ifu_pc_valid, o_ifu_pc, o_dec_valid, RV);
      else n_pass++;
      do_reset();
      dec_mode = 3;
      i_dec_ready = 1'b0;
      repeat (20) tick();
      n_checks++;
      if (n_acc != DEPTH) $display("FAIL midrst_credit: %0d accepts, required %0d", n_acc, DEPTH);
      else n_pass++;
      n_checks++;
      if (o_dec_valid !== 1'b1 || o_dec_pc !== RV)
         $display("FAIL midrst_head: valid=%b pc=%h, required 1/%h", o_dec_valid, o_dec_pc, RV);
      else n_pass++;
      dec_mode = 0;
      for (int i = 0; i < 40 && n_pop < 8; i++) tick();
      n_checks++;
      if (n_pop < 8) $display("FAIL midrst_resume: %0d pops, required 8", n_pop);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      lat = 3; ready_mode = 1; dec_mode = 1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            i_redirect_valid = 1'b1;
            i_redirect_pc = $urandom;
         end
         tick();
      end
      n_checks++;
      if (n_pop < 40) $display("FAIL random_progress: %0d pops, required >= 40", n_pop);
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_stream();
      test_dec_stall();
      test_ifu_stall();
      test_redirect();
      test_redirect_collision();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ladybird_fetch_ctrl.md
Name: ladybird_fetch_ctrl

Overview:
Fetch-control stage that wraps the instruction fetch unit on both sides.
- Upstream side: generates sequential PCs and drives the IFU request handshake (pc/pc_valid/pc_ready).
- Downstream side: captures IFU responses into a small instruction queue that feeds decode.
- The IFU has no response back-pressure, so issue is credit-limited: every accepted request owns a guaranteed queue slot.
- On a redirect (branch/trap), the queue is flushed and responses still in flight from the old path are discarded.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch target; bits[1:0] ignored (treated as 0)
- ifu_pc  out  XLEN  fetch address to IFU
- ifu_pc_valid  out  1  fetch request valid
- ifu_pc_ready  in  1  IFU accepts request
- ifu_inst  in  XLEN  fetched instruction
- ifu_inst_valid  in  1  response valid, one cycle, no back-pressure
- ifu_inst_pc  in  XLEN  PC of response
- dec_inst  out  XLEN  instruction to decode
- dec_pc  out  XLEN  its PC
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode consumes head

Behaviour:
- State registers:
  - next_pc, reset RESET_VECTOR.
  - req_valid/req_pc: the request register that drives ifu_pc_valid/ifu_pc. Reset values are 0 and RESET_VECTOR.
  - inflight: requests accepted by the IFU whose response has not returned.
  - drop_cnt: responses still to be discarded.
  - count: queue occupancy.
- All counters are $clog2(QUEUE_DEPTH)+1 bits wide; reset value 0.
- Reset outputs: ifu_pc_valid=0, ifu_pc=RESET_VECTOR, dec_valid=0, dec_inst/dec_pc=0.
- Request handshake:
  - ifu_pc_valid=req_valid.
  - Once asserted, ifu_pc_valid and ifu_pc stay stable until ifu_pc_ready. The request is never withdrawn, even on redirect.
- Request load:
  - Loading happens when the request register is empty, or is being accepted this cycle.
  - Conditions: no redirect this cycle, and credit available: inflight + req_valid + count - (pops this cycle) < QUEUE_DEPTH. Accepted requests are counted via inflight.
  - On load: req_pc<=next_pc, req_valid<=1, next_pc<=next_pc+4. The addition wraps modulo 2^XLEN.
  - First request: ifu_pc_valid rises in the first cycle after nrst deasserts.
- Acceptance: ifu_pc_valid & ifu_pc_ready -> inflight+1. req_valid clears unless it is reloaded in the same cycle.
- Response handling (ifu_inst_valid), inflight-1 in both cases:
  - If drop_cnt>0 (after this cycle's redirect update): discard the response and decrement drop_cnt.
  - Otherwise: push {ifu_inst, ifu_inst_pc} into the queue.
  - The credit rule guarantees the push never overflows. A push while full is an assertion failure.
- Redirect (takes priority over every other event in that cycle):
  - next_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - Queue flushed: count<=0, and dec_valid=0 in the next cycle. A same-cycle dec pop is ignored.
  - drop_cnt <= inflight + (req_valid ? 1 : 0) - (ifu_inst_valid ? 1 : 0). This counts the pending unaccepted request, which will still be issued, and excludes a response arriving that cycle, which is dropped directly.
  - No new request is loaded in the redirect cycle. The new path's first request is loaded the following cycle.
- Queue:
  - Synchronous FIFO; push and pop in the same cycle are allowed at any occupancy, including full.
  - No bypass: an instruction pushed in cycle N is visible on dec_* in cycle N+1 at the earliest.
  - dec_valid = count != 0. dec_inst/dec_pc hold the head entry while dec_valid & ~dec_ready.
- Steady state: with the IFU at 1 response/cycle and dec_ready=1, throughput is 1 instr/cycle when QUEUE_DEPTH >= IFU latency + 2.

Decomposition:
- ladybird_config package: XLEN (existing), plus new constant INST_BYTES=4 and a typedef fetch_entry_t {inst, pc}.
- Sub-module ladybird_fetch_queue: parameterised sync FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
- All credit, drop and PC logic stays in ladybird_fetch_ctrl.

Test Plan:
- Reset release, IFU ready always, fixed 2-cycle latency -> ifu_pc sequence 0x0,0x4,0x8,...; dec_pc matches in order; no gaps in the stream after fill.
- dec_ready=0 and QUEUE_DEPTH=4 -> exactly 4 requests are accepted, then ifu_pc_valid stays 0. The first dec_ready pulse permits exactly one more request.
- IFU holds ifu_pc_ready=0 for 5 cycles -> ifu_pc_valid=1 and ifu_pc constant throughout.
- Redirect to 0x100 while 2 requests are inflight and 1 is pending -> the next 3 responses are dropped, the queue is empty, and dec_pc resumes at 0x100, 0x104.
- Redirect in the same cycle as a response and a dec pop -> the response is dropped; dec_valid=0 next cycle; redirect_pc=0x203 fetches 0x200.
- next_pc=0xFFFF_FFFC -> the following request is 0x0000_0000; assert nrst mid-stream -> all counters 0, dec_valid=0, next fetch at RESET_VECTOR.
